// File: rtl/pc_r32i.sv
// Program counter for the RV32I fetch stage: sequential +PC_STEP or PC-relative branch.
// Optional macro PC_ALIGN_CHECK_EN rejects branch targets that are not word aligned.
module pc_r32i #(
  parameter int               dataW      = 32,
  parameter logic [dataW-1:0] RESET_ADDR = '0,
  parameter logic [dataW-1:0] PC_STEP    = dataW'(4)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCBranch,
  input  logic [dataW-1:0] BranchOffset,
  output logic [dataW-1:0] ProgAddr
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             AddrMisaligned
`endif
);

  logic [dataW-1:0] pc;
  logic [dataW-1:0] seq_addr;
  logic [dataW-1:0] br_addr;
  logic             take_branch;

  // Both adders wrap modulo 2^dataW; carry-out is intentionally dropped.
  assign seq_addr = pc + PC_STEP;
  assign br_addr  = pc + BranchOffset;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned  = PCBranch && (br_addr[1:0] != 2'b00);
  assign take_branch = PCBranch && !misaligned;

  always_ff @(posedge clock) begin
    if (reset) AddrMisaligned <= 1'b0;
    else       AddrMisaligned <= misaligned;
  end
`else
  assign take_branch = PCBranch;
`endif

  always_ff @(posedge clock) begin
    if (reset)            pc <= RESET_ADDR;
    else if (take_branch) pc <= br_addr;
    else                  pc <= seq_addr;
  end

  assign ProgAddr = pc;

endmodule

// File: tb/tb_pc_r32i.sv
// Directed, table-driven bench for pc_r32i; handles both PC_ALIGN_CHECK_EN builds.
module tb_pc_r32i;

  logic        clock;
  logic        reset;
  logic        PCBranch;
  logic [31:0] BranchOffset;
  logic [31:0] ProgAddr;
`ifdef PC_ALIGN_CHECK_EN
  logic        AddrMisaligned;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  pc_r32i #(.dataW(32), .RESET_ADDR(32'h0), .PC_STEP(32'd4)) dut (
    .clock        (clock),
    .reset        (reset),
    .PCBranch     (PCBranch),
    .BranchOffset (BranchOffset),
    .ProgAddr     (ProgAddr)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .AddrMisaligned (AddrMisaligned)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        br;
    logic [31:0] off;
    logic [31:0] exp;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  // driver: present inputs, take one rising edge, settle 1 time unit past it
  task automatic apply(input logic rst, input logic br, input logic [31:0] off);
    reset        = rst;
    PCBranch     = br;
    BranchOffset = off;
    @(posedge clock);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] exp, input logic exp_mis);
    n_vec++;
    if (ProgAddr !== exp) begin
      n_fail++;
      $display("FAIL %s: ProgAddr=%h expected %h", name, ProgAddr, exp);
    end
`ifdef PC_ALIGN_CHECK_EN
    n_vec++;
    if (AddrMisaligned !== exp_mis) begin
      n_fail++;
      $display("FAIL %s: AddrMisaligned=%b expected %b", name, AddrMisaligned, exp_mis);
    end
`else
    if (exp_mis !== 1'b0) $display("note: %s expects misalign flag in default build", name);
`endif
  endtask

  function automatic void add(input string name, input logic rst, input logic br,
                              input logic [31:0] off, input logic [31:0] exp,
                              input logic exp_mis);
    vec_t v;
    v.name = name; v.rst = rst; v.br = br; v.off = off; v.exp = exp; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endfunction

  initial begin
    reset        = 1'b1;
    PCBranch     = 1'b1;
    BranchOffset = 32'd89;

`ifdef PC_ALIGN_CHECK_EN
    add("reset_with_branch", 1, 1, 32'd89,       32'h0000_0000, 0);
    add("seq_1",             0, 0, 32'h0,        32'h0000_0004, 0);
    add("seq_2",             0, 0, 32'h0,        32'h0000_0008, 0);
    add("seq_3",             0, 0, 32'h0,        32'h0000_000C, 0);
    add("misaligned_89",     0, 1, 32'd89,       32'h0000_0010, 1);
    add("flag_clears",       0, 0, 32'h0,        32'h0000_0014, 0);
    add("branch_0x10",       0, 1, 32'h10,       32'h0000_0024, 0);
    add("hold_1",            0, 1, 32'h0,        32'h0000_0024, 0);
    add("hold_2",            0, 1, 32'h0,        32'h0000_0024, 0);
    add("signed_wrap",       0, 1, 32'h7FFF_FFFC, 32'h8000_0020, 0);
    add("seq_after_wrap",    0, 0, 32'h0,        32'h8000_0024, 0);
    add("unsigned_wrap",     0, 1, 32'h8000_0000, 32'h0000_0024, 0);
    add("to_0x100",          0, 1, 32'hDC,       32'h0000_0100, 0);
    add("neg_offset",        0, 1, 32'hFFFF_FFF0, 32'h0000_00F0, 0);
    add("mid_reset",         1, 1, 32'h40,       32'h0000_0000, 0);
    add("after_reset",       0, 0, 32'h0,        32'h0000_0004, 0);
    add("misaligned_2",      0, 1, 32'h2,        32'h0000_0008, 1);
    add("flag_one_cycle",    0, 0, 32'h0,        32'h0000_000C, 0);
    add("misaligned_neg1",   0, 1, 32'hFFFF_FFFF, 32'h0000_0010, 1);
    add("misaligned_then_rst", 1, 0, 32'h0,      32'h0000_0000, 0);
`else
    add("reset_with_branch", 1, 1, 32'd89,       32'h0000_0000, 0);
    add("seq_1",             0, 0, 32'h0,        32'h0000_0004, 0);
    add("seq_2",             0, 0, 32'h0,        32'h0000_0008, 0);
    add("seq_3",             0, 0, 32'h0,        32'h0000_000C, 0);
    add("branch_89",         0, 1, 32'd89,       32'h0000_0065, 0);
    add("hold_1",            0, 1, 32'h0,        32'h0000_0065, 0);
    add("hold_2",            0, 1, 32'h0,        32'h0000_0065, 0);
    add("seq_after_hold",    0, 0, 32'h0,        32'h0000_0069, 0);
    add("signed_wrap",       0, 1, 32'h7FFF_FFFF, 32'h8000_0068, 0);
    add("seq_after_wrap",    0, 0, 32'h0,        32'h8000_006C, 0);
    add("unsigned_wrap",     0, 1, 32'h7FFF_FFFF, 32'h0000_006B, 0);
    add("seq_odd_1",         0, 0, 32'h0,        32'h0000_006F, 0);
    add("seq_odd_2",         0, 0, 32'h0,        32'h0000_0073, 0);
    add("to_0x100",          0, 1, 32'h8D,       32'h0000_0100, 0);
    add("neg_offset",        0, 1, 32'hFFFF_FFF0, 32'h0000_00F0, 0);
    add("mid_reset",         1, 1, 32'h40,       32'h0000_0000, 0);
    add("after_reset",       0, 0, 32'h0,        32'h0000_0004, 0);
    add("unaligned_ok",      0, 1, 32'h2,        32'h0000_0006, 0);
    add("neg_one",           0, 1, 32'hFFFF_FFFF, 32'h0000_0005, 0);
    add("wrap_below_zero",   0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    add("seq_past_top",      0, 0, 32'h0,        32'h0000_0002, 0);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].br, vecs[i].off);
      check(vecs[i].name, vecs[i].exp, vecs[i].exp_mis);
    end

    // reset held several edges with arbitrary branch requests stays at RESET_ADDR
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} + 32'd8);
      check("reset_held", 32'h0, 1'b0);
    end

    // release into a branch from RESET_ADDR, then hold it for many cycles
    apply(1'b0, 1'b1, 32'h200);
    check("branch_from_reset", 32'h200, 1'b0);
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b1, 32'h0);
      check("long_hold", 32'h200, 1'b0);
    end
    apply(1'b0, 1'b0, 32'hDEAD_BEEF);
    check("seq_ignores_offset", 32'h204, 1'b0);

    // sequential run to a running expected value
    begin
      logic [31:0] exp_pc;
      exp_pc = 32'h204;
      for (int i = 0; i < 6; i++) begin
        exp_pc = exp_pc + 32'd4;
        apply(1'b0, 1'b0, 32'h0);
        check("seq_run", exp_pc, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
